sysid_reader: RTL and testbench

SYSID_READER -- requirements
Module: sysid_reader

---
 rtl/sysid_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_sysid_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_reader.sv
`default_nettype none
// ============================================================================
// Module   : sysid_reader
// Purpose  : Reads the two words of an Avalon-MM system-ID slave (ID word at
//            address 0, build timestamp at address 1) on request, captures
//            them, and reports whether both equal the expected values.
// Ports    : clock            - single clock, rising edge
//            reset            - synchronous active-high reset
//            start            - one-cycle request to run a check
//            avm_address      - 0 = ID word, 1 = timestamp word
//            avm_read         - Avalon-MM read strobe
//            avm_readdata     - read data from the sysid slave
//            avm_waitrequest  - slave stall
//            id_value         - captured ID word
//            ts_value         - captured timestamp word
//            busy             - high while a check is in progress
//            done             - one-cycle pulse when a check completes
//            match            - sticky: both words matched
//            timeout          - sticky: last check aborted on a stall
// Config   : define SYSID_READER_TIMEOUT_EN to add a per-read stall counter
//            that aborts a read after TIMEOUT_CYC stalled cycles. Without
//            it, reads wait indefinitely and timeout is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h5D30_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout
);

    // Parameter sanity check at elaboration time.
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_timeout_range_check
        $error("sysid_reader: TIMEOUT_CYC must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_rd_active;
    logic        w_rd_active_next;
    logic        w_start_acc;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        r_match;

`ifdef SYSID_READER_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_stall_cnt;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_abort;
    logic        r_timeout;
`endif

    // ------------------------------------------------------------------
    // State register. Reset has priority, so a start coincident with
    // reset is dropped and an in-flight read strobe falls next cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rd_active <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rd_active <= w_rd_active_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Each read state spends its first cycle with the
    // strobe low, then raises it; the strobe stays up (address fixed by
    // the state) until the slave releases waitrequest. That first idle
    // cycle of RD_TS is the mandatory gap between the two reads, and the
    // matching one in RD_ID keeps both reads symmetric.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_rd_active_next = r_rd_active;
        w_start_acc      = 1'b0;
        w_cap_id         = 1'b0;
        w_cap_ts         = 1'b0;
`ifdef SYSID_READER_TIMEOUT_EN
        w_cnt_clr        = 1'b0;
        w_cnt_inc        = 1'b0;
        w_abort          = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_rd_active_next = 1'b0;
                if (start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = RD_ID;
                end
            end
            RD_ID, RD_TS: begin
                if (!r_rd_active) begin
                    w_rd_active_next = 1'b1;
`ifdef SYSID_READER_TIMEOUT_EN
                    w_cnt_clr        = 1'b1;
`endif
                end else if (!avm_waitrequest) begin
                    w_rd_active_next = 1'b0;
                    if (r_state == RD_ID) begin
                        w_cap_id     = 1'b1;
                        w_state_next = RD_TS;
                    end else begin
                        w_cap_ts     = 1'b1;
                        w_state_next = FINISH;
                    end
                end else begin
`ifdef SYSID_READER_TIMEOUT_EN
                    // This stalled cycle is the TIMEOUT_CYC-th one.
                    if (r_stall_cnt == C_TIMEOUT_LAST) begin
                        w_abort          = 1'b1;
                        w_rd_active_next = 1'b0;
                        w_state_next     = FINISH;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
`endif
                end
            end
            FINISH: begin
                w_rd_active_next = 1'b0;
                w_state_next     = IDLE;
            end
            default: begin
                w_rd_active_next = 1'b0;
                w_state_next     = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture and status registers. The match flag is evaluated on the
    // timestamp capture edge using the live read data, so it is valid in
    // the same cycle as the done pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id_value <= 32'h0;
            r_ts_value <= 32'h0;
            r_match    <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_match <= 1'b0;
            end
            if (w_cap_id) begin
                r_id_value <= avm_readdata;
            end
            if (w_cap_ts) begin
                r_ts_value <= avm_readdata;
                r_match    <= (r_id_value == EXPECTED_ID) &&
                              (avm_readdata == EXPECTED_TS);
            end
`ifdef SYSID_READER_TIMEOUT_EN
            if (w_abort) begin
                r_match <= 1'b0;
            end
`endif
        end
    end

`ifdef SYSID_READER_TIMEOUT_EN
    // Stall counter: cleared as each read begins, counts strobe-high
    // cycles that the slave stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= 16'h0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_stall_cnt <= 16'h0;
            end else if (w_cnt_inc) begin
                r_stall_cnt <= r_stall_cnt + 16'h1;
            end
            if (w_start_acc) begin
                r_timeout <= 1'b0;
            end else if (w_abort) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign avm_read    = r_rd_active;
    assign avm_address = (r_state == RD_TS);
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == FINISH);
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;
    assign match       = r_match;

endmodule
`default_nettype wire

// File: tb/tb_sysid_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sysid_reader
// Purpose  : Scoreboard bench for sysid_reader. Each accepted start pushes
//            the expected done cycle and result words; a monitor pops and
//            compares on every done pulse. A small Avalon slave model
//            supplies data with a programmable number of stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h5D30_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        match;
    logic        timeout;

    sysid_reader #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .TIMEOUT_CYC (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .busy            (busy),
        .done            (done),
        .match           (match),
        .timeout         (timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Slave model: stalls each read for stall_n cycles.
    int          stall_n   = 0;
    int          stall_cnt = 0;
    logic [31:0] slv_id;
    logic [31:0] slv_ts;

    always @(posedge clock) begin
        if (!avm_read)            stall_cnt <= 0;
        else if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
    end
    assign avm_waitrequest = avm_read && (stall_cnt < stall_n);
    assign avm_readdata    = avm_address ? slv_ts : slv_id;

    typedef struct {
        int          cyc;
        logic [31:0] id;
        logic [31:0] ts;
        logic        m;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    exp_t e;
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc,      e.cyc);
                chk("id_value",   id_value, e.id);
                chk("ts_value",   ts_value, e.ts);
                chk("match",      match,    e.m);
                chk("timeout",    timeout,  e.to);
            end
        end
    end

    // Read strobe and address must hold steady through a stall.
    bit   stall_chk_en = 1'b1;
    bit   prev_stall   = 1'b0;
    logic prev_addr    = 1'b0;
    always @(negedge clock) begin
        if (prev_stall && stall_chk_en) begin
            chk("stall_read_held", avm_read,    1'b1);
            chk("stall_addr_held", avm_address, prev_addr);
        end
        prev_stall = avm_read && avm_waitrequest && !reset;
        prev_addr  = avm_address;
    end

    task automatic pulse_start(input bit expect_done, input int lat,
                               input logic [31:0] id, input logic [31:0] ts,
                               input logic m, input logic to);
        exp_t x;
        @(posedge clock); #1;
        start = 1'b1;
        if (expect_done) begin
            x = '{cyc + lat, id, ts, m, to};
            sb.push_back(x);
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_wait: actual=pending_%0d required=pending_0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        slv_id = EXP_ID;
        slv_ts = EXP_TS;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_avm_read", avm_read,    1'b0);
        chk("rst_avm_addr", avm_address, 1'b0);
        chk("rst_busy",     busy,        1'b0);
        chk("rst_done",     done,        1'b0);
        chk("rst_match",    match,       1'b0);
        chk("rst_timeout",  timeout,     1'b0);
        chk("rst_id",       id_value,    32'h0);
        chk("rst_ts",       ts_value,    32'h0);

        // Nominal check, zero stall: done 5 cycles after start
        pulse_start(1'b1, 5, 32'h0, 32'h5D30_0000, 1'b1, 1'b0);
        wait_drain("nominal", 40);
        chk("busy_after_done", busy, 1'b0);

        // Wrong timestamp
        slv_ts = 32'h5D30_0001;
        pulse_start(1'b1, 5, 32'h0, 32'h5D30_0001, 1'b0, 1'b0);
        wait_drain("bad_ts", 40);

        // Three stall cycles on each read: done at cycle 11
        slv_ts  = EXP_TS;
        stall_n = 3;
        pulse_start(1'b1, 11, 32'h0, 32'h5D30_0000, 1'b1, 1'b0);
        wait_drain("stall3", 60);
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("match_sticky", match, 1'b1);

        // Wrong ID, one stall each read
        stall_n = 1;
        slv_id  = 32'h1234_5678;
        pulse_start(1'b1, 7, 32'h1234_5678, 32'h5D30_0000, 1'b0, 1'b0);
        wait_drain("bad_id", 40);

        // Second start while in RD_TS is ignored
        stall_n = 0;
        slv_id  = EXP_ID;
        pulse_start(1'b1, 5, 32'h0, 32'h5D30_0000, 1'b1, 1'b0);
        @(posedge clock);
        @(posedge clock); #1;
        chk("addr_in_rd_ts", avm_address, 1'b1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_drain("restart_ignored", 40);
        repeat (8) @(posedge clock);

        // Reset during a stalled ID read
        stall_n = 3;
        pulse_start(1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk("read_before_reset", avm_read, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_read",    avm_read,    1'b0);
        chk("rst_mid_addr",    avm_address, 1'b0);
        chk("rst_mid_busy",    busy,        1'b0);
        chk("rst_mid_done",    done,        1'b0);
        chk("rst_mid_match",   match,       1'b0);
        chk("rst_mid_timeout", timeout,     1'b0);
        chk("rst_mid_id",      id_value,    32'h0);
        chk("rst_mid_ts",      ts_value,    32'h0);
        repeat (12) @(posedge clock);

        // Start coincident with reset is dropped
        stall_n = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("start_in_reset_busy0", busy, 1'b0);
        @(negedge clock);
        chk("start_in_reset_busy1", busy, 1'b0);
        chk("start_in_reset_read",  avm_read, 1'b0);
        repeat (8) @(posedge clock);

`ifdef SYSID_READER_TIMEOUT_EN
        // Slave stuck in waitrequest: read aborts after 4 stalled cycles
        stall_chk_en = 1'b0;
        stall_n      = 1000;
        pulse_start(1'b1, 6, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clock);
        chk("to_setup_read", avm_read, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("to_stall_read", avm_read, 1'b1);
        end
        @(negedge clock);
        chk("to_read_dropped", avm_read, 1'b0);
        wait_drain("timeout", 40);
        repeat (8) @(posedge clock);
        stall_n      = 0;
        stall_chk_en = 1'b1;
        pulse_start(1'b1, 5, 32'h0, 32'h5D30_0000, 1'b1, 1'b0);
        wait_drain("after_timeout", 40);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
